// File: rtl/apb_rr_master.sv
// apb_rr_master: four-requester round-robin arbiter driving a single APB master
// port. Each granted request becomes one SETUP + ACCESS transfer. The owner sees
// a one-cycle done pulse, with rdata (reads) and err. All outputs are registered.
//
// Optional build macro:
//   APB_TIMEOUT_EN : count ACCESS cycles and abort with err=1 after TIMEOUT
//                    cycles without a completing pready. Undefined (default):
//                    no counter, err is always 0, ACCESS waits indefinitely.
module apb_rr_master #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [8*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rdata,
    output logic              err,
    output logic [NREQ-1:0]   gnt,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [7:0]        paddr,
    output logic [7:0]        pwdata,
    input  logic              pready,
    input  logic [7:0]        prdata
);

    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [PTR_W-1:0] owner, owner_nxt;
    logic             first_acc, first_acc_nxt;

    logic [NREQ-1:0]  done_nxt, gnt_nxt;
    logic [7:0]       rdata_nxt, paddr_nxt, pwdata_nxt;
    logic             err_nxt, psel_nxt, penable_nxt, pwrite_nxt;

    logic             pick_found;
    logic [PTR_W-1:0] pick_idx, cand;
    logic             timed_out;

`ifdef APB_TIMEOUT_EN
    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] acc_cnt, acc_cnt_nxt;

    // The current ACCESS cycle is the last one allowed before the watchdog fires.
    assign timed_out = (acc_cnt == CNT_LIMIT);

    // ACCESS-cycle counter: 1 in the first ACCESS cycle, counts up from there.
    always_ff @(posedge clk) begin
        if (rst) acc_cnt <= '0;
        else     acc_cnt <= acc_cnt_nxt;
    end
`else
    // Without the watchdog, ACCESS only ends on pready.
    assign timed_out = 1'b0;

    // Keeps TIMEOUT referenced in builds that do not use it.
    logic [31:0] timeout_unused;
    assign timeout_unused = TIMEOUT;
`endif

    // Round-robin pick: first requester at or after ptr, wrapping past the top index.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr;
        cand       = ptr;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr + PTR_W'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequencer.
    // NOTE: every *_nxt is given a default before the case so no path leaves a
    // variable unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        owner_nxt     = owner;
        first_acc_nxt = first_acc;
        gnt_nxt       = gnt;
        psel_nxt      = psel;
        penable_nxt   = penable;
        pwrite_nxt    = pwrite;
        paddr_nxt     = paddr;
        pwdata_nxt    = pwdata;
        done_nxt      = '0;
        rdata_nxt     = 8'h00;
        err_nxt       = 1'b0;
`ifdef APB_TIMEOUT_EN
        acc_cnt_nxt   = acc_cnt;
`endif

        unique case (state)
            IDLE: begin
                // done still high means the previous transfer just finished:
                // hold off one cycle so the bus shows a clean idle gap.
                if (done == '0 && pick_found) begin
                    state_nxt  = SETUP;
                    owner_nxt  = pick_idx;
                    gnt_nxt    = NREQ'(1) << pick_idx;
                    psel_nxt   = 1'b1;
                    pwrite_nxt = req_wr[pick_idx];
                    paddr_nxt  = req_addr[8*pick_idx +: 8];
                    pwdata_nxt = req_wdata[8*pick_idx +: 8];
                end
            end

            SETUP: begin
                state_nxt     = ACCESS;
                penable_nxt   = 1'b1;
                first_acc_nxt = 1'b1;
`ifdef APB_TIMEOUT_EN
                acc_cnt_nxt   = 1;
`endif
            end

            ACCESS: begin
                first_acc_nxt = 1'b0;
`ifdef APB_TIMEOUT_EN
                acc_cnt_nxt   = acc_cnt + 1'b1;
`endif
                // pready is not looked at in the first ACCESS cycle.
                if ((!first_acc && pready) || timed_out) begin
                    state_nxt   = IDLE;
                    psel_nxt    = 1'b0;
                    penable_nxt = 1'b0;
                    gnt_nxt     = '0;
                    done_nxt    = gnt;
                    ptr_nxt     = owner + 1'b1;
                    if (!first_acc && pready) rdata_nxt = pwrite ? 8'h00 : prdata;
                    else                      err_nxt   = 1'b1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs.
    // NOTE: rst is synchronous: it is only seen on a rising clk edge, and it
    // clears every register, including ones in the middle of a transfer.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            first_acc <= 1'b0;
            gnt       <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= 8'h00;
            pwdata    <= 8'h00;
            done      <= '0;
            rdata     <= 8'h00;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            first_acc <= first_acc_nxt;
            gnt       <= gnt_nxt;
            psel      <= psel_nxt;
            penable   <= penable_nxt;
            pwrite    <= pwrite_nxt;
            paddr     <= paddr_nxt;
            pwdata    <= pwdata_nxt;
            done      <= done_nxt;
            rdata     <= rdata_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master. The bench acts as the requesters and
// as an 8-bit-addressed APB slave backed by a memory model. A transaction-level
// reference keeps the round-robin pointer and memory contents, and knows the
// cycle timing of each transfer. Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_apb_rr_master;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  done, gnt;
    logic [7:0]  rdata, paddr, pwdata, prdata;
    logic        err, psel, penable, pwrite, pready;

    int          errors = 0;
    int          checks = 0;

    // Reference state: next round-robin start point and slave memory.
    int          m_ptr;
    logic [7:0]  mem [256];

    always #5 clk = ~clk;

    apb_rr_master #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .gnt       (gnt),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bus idle and no completion being reported.
    task automatic check_idle(input string tag);
        check({tag, "_psel"},    32'(psel),    32'd0);
        check({tag, "_penable"}, 32'(penable), 32'd0);
        check({tag, "_gnt"},     32'(gnt),     32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_rdata"},   32'(rdata),   32'd0);
        check({tag, "_err"},     32'(err),     32'd0);
    endtask

    // Every output at zero.
    task automatic check_reset_state(input string tag);
        check_idle(tag);
        check({tag, "_pwrite"}, 32'(pwrite), 32'd0);
        check({tag, "_paddr"},  32'(paddr),  32'd0);
        check({tag, "_pwdata"}, 32'(pwdata), 32'd0);
    endtask

    // Round-robin choice: first set bit at or after p, wrapping 3 -> 0.
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++)
            if (r[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    // Change a requester's inputs at random, including dropping its request.
    task automatic scramble(input int o);
        req[o]              = 1'($urandom);
        req_wr[o]           = 1'($urandom);
        req_addr[8*o +: 8]  = 8'($urandom);
        req_wdata[8*o +: 8] = 8'($urandom);
    endtask

    // One full transfer. On entry: falling edge of an arbitration cycle, with
    // req already driven and the DUT idle. acc_len (>= 2) is the number of
    // ACCESS cycles; first_pready is driven in the first ACCESS cycle, where it
    // must be ignored. On exit: falling edge of the next arbitration cycle.
    task automatic transfer(input int acc_len, input logic first_pready,
                            input bit scr, input bit keep_req, output int owner);
        int         o;
        logic       e_wr;
        logic [7:0] e_addr, e_wd, e_rd;
        o = rr_pick(req, m_ptr);
        owner = o;
        if (o < 0) begin
            checks++;
            errors++;
            $display("FAIL arb_req: no request pending at arbitration");
            return;
        end
        e_wr   = req_wr[o];
        e_addr = req_addr[8*o +: 8];
        e_wd   = req_wdata[8*o +: 8];
        pready = 1'($urandom);
        prdata = 8'($urandom);

        @(negedge clk);  // SETUP
        check("setup_psel",    32'(psel),    32'd1);
        check("setup_penable", 32'(penable), 32'd0);
        check("setup_gnt",     32'(gnt),     32'(1 << o));
        check("setup_pwrite",  32'(pwrite),  32'(e_wr));
        check("setup_paddr",   32'(paddr),   32'(e_addr));
        check("setup_pwdata",  32'(pwdata),  32'(e_wd));
        check("setup_done",    32'(done),    32'd0);
        if (scr) scramble(o);
        pready = 1'($urandom);
        prdata = 8'($urandom);

        for (int k = 1; k <= acc_len; k++) begin
            @(negedge clk);  // ACCESS cycle k
            check("acc_psel",    32'(psel),    32'd1);
            check("acc_penable", 32'(penable), 32'd1);
            check("acc_gnt",     32'(gnt),     32'(1 << o));
            check("acc_pwrite",  32'(pwrite),  32'(e_wr));
            check("acc_paddr",   32'(paddr),   32'(e_addr));
            check("acc_pwdata",  32'(pwdata),  32'(e_wd));
            check("acc_done",    32'(done),    32'd0);
            pready = (k == 1) ? first_pready : (k == acc_len);
            prdata = (k == acc_len) ? mem[e_addr] : 8'($urandom);
            if (scr) scramble(o);
        end

        e_rd = e_wr ? 8'h00 : mem[e_addr];
        @(negedge clk);  // completion cycle
        check("done_pulse",   32'(done),    32'(1 << o));
        check("done_rdata",   32'(rdata),   32'(e_rd));
        check("done_err",     32'(err),     32'd0);
        check("done_psel",    32'(psel),    32'd0);
        check("done_penable", 32'(penable), 32'd0);
        check("done_gnt",     32'(gnt),     32'd0);
        if (e_wr) mem[e_addr] = e_wd;
        m_ptr  = (o + 1) % 4;
        pready = 1'b0;
        if (!keep_req) req[o] = 1'b0;

        @(negedge clk);  // no arbitration happened during the completion cycle
        check_idle("gap");
    endtask

    initial begin
        int o;
        rst       = 1'b1;
        req       = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        prdata    = 8'h00;
        m_ptr     = 0;
        foreach (mem[i]) mem[i] = 8'($urandom);

        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Single write from requester 0 with pready high throughout.
        req = 4'b0001; req_wr = 4'b0001;
        req_addr[7:0] = 8'h10; req_wdata[7:0] = 8'hA5;
        transfer(2, 1'b1, 1'b0, 1'b0, o);

        // Write then read back through requester 2.
        req_wr[2] = 1'b1; req_addr[23:16] = 8'h22; req_wdata[23:16] = 8'h3C;
        req = 4'b0100;
        transfer(2, 1'b1, 1'b0, 1'b0, o);
        req_wr[2] = 1'b0; req = 4'b0100;
        transfer(2, 1'b1, 1'b0, 1'b0, o);
        check("readback_mem", 32'(mem[8'h22]), 32'h3C);

        // Wait states: pready low for three ACCESS cycles, high on the fourth.
        req_wr[0] = 1'b0; req_addr[7:0] = 8'h22; req = 4'b0001;
        transfer(4, 1'b0, 1'b0, 1'b0, o);

        // Reset during ACCESS: everything clears, no completion, pointer back to 0.
        req = 4'b1000; req_wr[3] = 1'b1; req_addr[31:24] = 8'h55; req_wdata[31:24] = 8'h66;
        @(negedge clk);  // SETUP
        @(negedge clk);  // ACCESS
        check("midop_penable", 32'(penable), 32'd1);
        rst = 1'b1; pready = 1'b1;
        @(negedge clk);
        check_reset_state("midop_rst");
        rst = 1'b0; pready = 1'b0; m_ptr = 0;

        // Round robin with all four held: grants 0,1,2,3,0, five cycles apart.
        req = 4'b1111; req_wr = 4'b0101;
        req_addr = 32'h0C08_0400; req_wdata = 32'hD4C3_B2A1;
        for (int n = 0; n < 5; n++) transfer(2, 1'b1, 1'b0, 1'b1, o);
        req = '0;
        @(negedge clk);
        check_idle("rr_drain");

`ifdef APB_TIMEOUT_EN
        // Watchdog: slave never ready; abort after TIMEOUT ACCESS cycles.
        req = 4'b0010; req_wr[1] = 1'b0; req_addr[15:8] = 8'h22;
        o = rr_pick(req, m_ptr);
        pready = 1'b0;
        @(negedge clk);  // SETUP
        check("to_setup_psel", 32'(psel), 32'd1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            check("to_acc_penable", 32'(penable), 32'd1);
            check("to_acc_done",    32'(done),    32'd0);
        end
        @(negedge clk);
        check("to_done",  32'(done),  32'(1 << o));
        check("to_err",   32'(err),   32'd1);
        check("to_rdata", 32'(rdata), 32'd0);
        m_ptr = (o + 1) % 4;
        req = '0;
        @(negedge clk);
        check_idle("to_after");
`endif

        // Random traffic: requesters raise requests at random, owners change
        // their inputs mid-transfer, and the slave inserts random wait states.
        for (int n = 0; n < 250; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i]              = 1'b1;
                    req_wr[i]           = 1'($urandom);
                    req_addr[8*i +: 8]  = 8'($urandom_range(0, 15));
                    req_wdata[8*i +: 8] = 8'($urandom);
                end
            end
            if (req == 4'b0000) begin
                pready = 1'($urandom);
                @(negedge clk);
                check("idle_psel", 32'(psel), 32'd0);
                check("idle_gnt",  32'(gnt),  32'd0);
            end else begin
                transfer($urandom_range(2, 6), 1'($urandom), 1'b1, 1'($urandom), o);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
